vdp_vram_arbiter: RTL and testbench

Shares the single VRAM port of the `ip_sdram` controller between the four VDP VRAM requesters (screen fetch, sprite fetch, CPU port, command engine). Sits inside `vdp` between the internal requesters and the `vram_*` top-level port. It serialises transactions with one transaction outstanding, applies fixed priority plus round-robin, and holds off all accesses while the SDRAM is initialising.

---
 rtl/vdp_vram_pkg.sv | 23 ++
 rtl/vdp_vram_arb_select.sv | 30 +++
 rtl/vdp_vram_arbiter.sv | 143 ++++++++++++++
 tb/tb_vdp_vram_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_vram_pkg.sv
// VDP VRAM arbiter shared package.
// Requester indices, FSM state type and VRAM address width.
package vdp_vram_pkg;

  localparam int VRAM_ADDR_W = 17;

  localparam logic [1:0] REQ_SCREEN  = 2'd0;
  localparam logic [1:0] REQ_SPRITE  = 2'd1;
  localparam logic [1:0] REQ_CPU     = 2'd2;
  localparam logic [1:0] REQ_COMMAND = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_WR,
    WAIT_RD
  } vram_arb_state_t;

  function automatic logic [3:0] req_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/vdp_vram_arb_select.sv
// VDP VRAM winner selector: screen > sprite > {CPU, command}.
// CPU/command tie is broken by rr_i (0 = CPU first).
module vdp_vram_arb_select
  import vdp_vram_pkg::*;
(
  input  logic [3:0] req_valid_i,
  input  logic       rr_i,
  output logic [1:0] idx_o,
  output logic       hit_o
);

  // Fixed priority with a round-robin pair at the bottom
  always_comb begin
    idx_o = REQ_SCREEN;
    hit_o = |req_valid_i;
    if (req_valid_i[REQ_SCREEN]) begin
      idx_o = REQ_SCREEN;
    end else if (req_valid_i[REQ_SPRITE]) begin
      idx_o = REQ_SPRITE;
    end else if (req_valid_i[REQ_CPU] &&
                 req_valid_i[REQ_COMMAND]) begin
      idx_o = rr_i ? REQ_COMMAND : REQ_CPU;
    end else if (req_valid_i[REQ_CPU]) begin
      idx_o = REQ_CPU;
    end else if (req_valid_i[REQ_COMMAND]) begin
      idx_o = REQ_COMMAND;
    end
  end

endmodule

// File: rtl/vdp_vram_arbiter.sv
// VDP VRAM arbiter: one outstanding SDRAM transaction, four requesters.
// Optional read timeout enabled by defining VDP_VRAM_ARB_TIMEOUT_EN.
module vdp_vram_arbiter
  import vdp_vram_pkg::*;
#(
  parameter int WRITE_GAP    = 4,
  parameter int READ_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   initial_busy,
  input  logic [3:0]             req_valid,
  input  logic [3:0]             req_write,
  input  logic [67:0]            req_address,
  input  logic [31:0]            req_wdata,
  output logic [3:0]             req_ready,
  output logic [31:0]            req_rdata,
  output logic [3:0]             req_rdata_en,
  output logic [VRAM_ADDR_W-1:0] vram_address,
  output logic                   vram_write,
  output logic                   vram_valid,
  output logic [7:0]             vram_wdata,
  input  logic [31:0]            vram_rdata,
  input  logic                   vram_rdata_en,
  output logic                   timeout_error
);

  localparam logic [3:0] GAP_LOAD = 4'(WRITE_GAP - 1);

  vram_arb_state_t        state_q;
  logic                   rr_q;
  logic [1:0]             owner_q;
  logic [3:0]             gap_q;
  logic [1:0]             win;
  logic                   hit;
  logic [VRAM_ADDR_W-1:0] win_addr;
  logic [7:0]             win_wdata;
  logic                   win_write;

`ifdef VDP_VRAM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(READ_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(READ_TIMEOUT - 1);
  logic [TO_W-1:0] to_q;
  logic            to_err_q;
  assign timeout_error = to_err_q;
`else
  logic unused_read_timeout;
  assign unused_read_timeout = (READ_TIMEOUT != 0);
  assign timeout_error = 1'b0;
`endif

  vdp_vram_arb_select u_select (
    .req_valid_i (req_valid),
    .rr_i        (rr_q),
    .idx_o       (win),
    .hit_o       (hit)
  );

  // Steer the winning requester's fields onto the issue path
  always_comb begin
    win_addr  = req_address[VRAM_ADDR_W*32'(win) +: VRAM_ADDR_W];
    win_wdata = req_wdata[8*32'(win) +: 8];
    win_write = req_write[win];
  end

  // Arbitration FSM with registered issue, handshake and read-return outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      owner_q      <= '0;
      gap_q        <= '0;
      vram_address <= '0;
      vram_write   <= 1'b0;
      vram_wdata   <= '0;
      vram_valid   <= 1'b0;
      req_ready    <= '0;
      req_rdata    <= '0;
      req_rdata_en <= '0;
`ifdef VDP_VRAM_ARB_TIMEOUT_EN
      to_q         <= '0;
      to_err_q     <= 1'b0;
`endif
    end else begin
      vram_valid   <= 1'b0;
      req_ready    <= '0;
      req_rdata_en <= '0;
      unique case (state_q)
        IDLE: begin
          if (!initial_busy && hit) begin
            state_q      <= ISSUE;
            owner_q      <= win;
            vram_address <= win_addr;
            vram_write   <= win_write;
            vram_wdata   <= win_wdata;
            vram_valid   <= 1'b1;
            req_ready    <= req_onehot(win);
            if (win == REQ_CPU) begin
              rr_q <= 1'b1;
            end else if (win == REQ_COMMAND) begin
              rr_q <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (vram_write) begin
            state_q <= WAIT_WR;
            gap_q   <= GAP_LOAD;
          end else begin
            state_q <= WAIT_RD;
`ifdef VDP_VRAM_ARB_TIMEOUT_EN
            to_q    <= '0;
`endif
          end
        end
        WAIT_WR: begin
          if (gap_q == 4'd0) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        WAIT_RD: begin
          if (vram_rdata_en) begin
            state_q               <= IDLE;
            req_rdata             <= vram_rdata;
            req_rdata_en[owner_q] <= 1'b1;
          end
`ifdef VDP_VRAM_ARB_TIMEOUT_EN
          else if (to_q == TO_LAST) begin
            state_q  <= IDLE;
            to_err_q <= 1'b1;
          end else begin
            to_q <= to_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Self-checking bench for vdp_vram_arbiter.
// Vector table plus hand sequences; grant/read scoreboard queues.
module tb_vdp_vram_arbiter;
  import vdp_vram_pkg::*;

  localparam int G   = 4;
  localparam int TO  = 64;
  localparam int LAT = 7;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        initial_busy;
  logic [3:0]  req_valid;
  logic [3:0]  req_write;
  logic [67:0] req_address;
  logic [31:0] req_wdata;
  logic [3:0]  req_ready;
  logic [31:0] req_rdata;
  logic [3:0]  req_rdata_en;
  logic [16:0] vram_address;
  logic        vram_write;
  logic        vram_valid;
  logic [7:0]  vram_wdata;
  logic [31:0] vram_rdata;
  logic        vram_rdata_en;
  logic        timeout_error;

  always #5 clk = ~clk;

  vdp_vram_arbiter #(
    .WRITE_GAP    (G),
    .READ_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .initial_busy  (initial_busy),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_address   (req_address),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .req_rdata     (req_rdata),
    .req_rdata_en  (req_rdata_en),
    .vram_address  (vram_address),
    .vram_write    (vram_write),
    .vram_valid    (vram_valid),
    .vram_wdata    (vram_wdata),
    .vram_rdata    (vram_rdata),
    .vram_rdata_en (vram_rdata_en),
    .timeout_error (timeout_error)
  );

  typedef struct packed {
    logic [3:0]  ready;
    logic [16:0] addr;
    logic        write;
    logic [7:0]  wdata;
  } gexp_t;

  typedef struct packed {
    logic [3:0]  en;
    logic [31:0] data;
  } rexp_t;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] wr;
    int         n;
    int         ord[4];
  } vec_t;

  gexp_t       gq[$];
  rexp_t       rq[$];
  vec_t        vt[10];
  int          n_cmp, n_err;
  int          cyc, rd_cnt, rden_cyc, last_iss, issues;
  int          rem[4];
  logic        last_wr, sdram_en, fix_en;
  logic [31:0] fix_data;
  logic [16:0] rd_addr;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [16:0] a);
    return 32'h9E37_79B9 ^ {15'd0, a};
  endfunction

  function automatic logic [31:0] rdval(input logic [16:0] a);
    return fix_en ? fix_data : mem_data(a);
  endfunction

  function automatic logic [16:0] mk_addr(input int v, input int i);
    return 17'(256 + v * 1024 + i * 17);
  endfunction

  function automatic logic [7:0] mk_wd(input int v, input int i);
    return 8'(48 + v * 16 + i);
  endfunction

  task automatic set_req(input int i, input logic [16:0] a,
                         input logic w, input logic [7:0] d);
    req_address[17*i +: 17] = a;
    req_wdata[8*i +: 8]     = d;
    req_write[i]            = w;
  endtask

  task automatic push_grant(input int i);
    gexp_t g;
    g.ready = 4'(1 << i);
    g.addr  = req_address[17*i +: 17];
    g.write = req_write[i];
    g.wdata = req_wdata[8*i +: 8];
    gq.push_back(g);
  endtask

  task automatic on_issue();
    gexp_t a, g;
    rexp_t r;
    issues++;
    a.ready = req_ready;
    a.addr  = vram_address;
    a.write = vram_write;
    a.wdata = vram_wdata;
    if (last_iss >= 0 && last_wr) begin
      n_cmp++;
      if (cyc - last_iss < G + 2) begin
        n_err++;
        $display("FAIL write_gap: got %0d expected >= %0d",
                 cyc - last_iss, G + 2);
      end
    end
    last_iss = cyc;
    last_wr  = vram_write;
    if (gq.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_issue: got %0h expected none", a);
    end else begin
      g = gq.pop_front();
      chk("issue", 64'(a), 64'(g));
      if (!g.write && sdram_en) begin
        r.en   = g.ready;
        r.data = rdval(g.addr);
        rq.push_back(r);
        rd_cnt  = LAT;
        rd_addr = vram_address;
      end
    end
  endtask

  task automatic on_read();
    rexp_t a, r;
    a.en   = req_rdata_en;
    a.data = req_rdata;
    if (rq.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL stray_rdata_en: got %0h expected none", a);
    end else begin
      r = rq.pop_front();
      chk("rdata", 64'(a), 64'(r));
      chk("rdata_latency", 64'(cyc), 64'(rden_cyc + 1));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    vram_rdata_en = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        vram_rdata_en = 1'b1;
        vram_rdata    = rdval(rd_addr);
        rden_cyc      = cyc;
      end
    end
    chk("ready_implies_valid", 64'(req_ready != 4'd0), 64'(vram_valid));
    if (vram_valid) on_issue();
    if (req_rdata_en != 4'd0) on_read();
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i]) begin
        if (rem[i] > 0) rem[i]--;
        if (rem[i] == 0) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic drain(input int budget);
    int  k;
    bit  done;
    k    = 0;
    done = 0;
    while (!done && k < budget) begin
      if (gq.size() == 0 && rq.size() == 0 && req_valid == 4'd0)
        done = 1;
      else begin
        tick();
        k++;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d grants %0d reads pending expected 0",
               gq.size(), rq.size());
      gq.delete();
      rq.delete();
      req_valid = '0;
    end
    repeat (G + 3) tick();
  endtask

  task automatic set_vec(input int k, input logic [3:0] v,
                         input logic [3:0] w, input int n,
                         input int o0, input int o1,
                         input int o2, input int o3);
    vt[k].valid  = v;
    vt[k].wr     = w;
    vt[k].n      = n;
    vt[k].ord[0] = o0;
    vt[k].ord[1] = o1;
    vt[k].ord[2] = o2;
    vt[k].ord[3] = o3;
  endtask

  initial begin
    int t0, n0, k;

    n_cmp = 0; n_err = 0; cyc = 0; rd_cnt = 0; rden_cyc = -10;
    last_iss = -1; last_wr = 1'b0; issues = 0;
    sdram_en = 1'b1; fix_en = 1'b0; fix_data = '0; rd_addr = '0;
    for (int i = 0; i < 4; i++) rem[i] = 0;
    reset_n = 1'b0; initial_busy = 1'b0;
    req_valid = '0; req_write = '0; req_address = '0; req_wdata = '0;
    vram_rdata = '0; vram_rdata_en = 1'b0;

    // rr enters the table pointing at command (see hand sequences)
    set_vec(0, 4'b0001, 4'b0001, 1, 0, 0, 0, 0);
    set_vec(1, 4'b1111, 4'b1010, 4, 0, 1, 3, 2);
    set_vec(2, 4'b1100, 4'b0000, 2, 3, 2, 0, 0);
    set_vec(3, 4'b1000, 4'b1000, 1, 3, 0, 0, 0);
    set_vec(4, 4'b1100, 4'b1100, 2, 2, 3, 0, 0);
    set_vec(5, 4'b0100, 4'b0000, 1, 2, 0, 0, 0);
    set_vec(6, 4'b1100, 4'b0000, 2, 3, 2, 0, 0);
    set_vec(7, 4'b1110, 4'b0110, 3, 1, 3, 2, 0);
    set_vec(8, 4'b0110, 4'b0000, 2, 1, 2, 0, 0);
    set_vec(9, 4'b1001, 4'b0001, 2, 0, 3, 0, 0);

    // reset state
    repeat (3) tick();
    chk("reset_outs_a", 64'({req_ready, req_rdata_en, vram_address,
                             vram_write, vram_valid, vram_wdata}), 64'd0);
    chk("reset_outs_b", 64'({req_rdata, timeout_error}), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("post_reset_valid", 64'(vram_valid), 64'd0);

    // init busy holds off everything, then screen first
    initial_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(i, mk_addr(30, i), 1'b0, mk_wd(30, i));
      rem[i] = 1;
    end
    req_valid = 4'hF;
    repeat (1000) tick();
    chk("busy_hold_issues", 64'(issues), 64'd0);
    for (int i = 0; i < 4; i++) push_grant(i);
    initial_busy = 1'b0;
    tick();
    chk("busy_drop_latency", 64'(vram_valid), 64'd1);
    chk("busy_drop_screen", 64'(req_ready), 64'(4'b0001));
    drain(300);

    // screen write, then exact write spacing to a pending sprite read
    set_req(0, 17'h1_0000, 1'b1, 8'hA5);
    push_grant(0);
    rem[0] = 1;
    req_valid[0] = 1'b1;
    tick();
    chk("wr_issue_seen", 64'(vram_valid), 64'd1);
    t0 = cyc;
    set_req(1, 17'h0_0456, 1'b0, 8'h00);
    push_grant(1);
    rem[1] = 1;
    req_valid[1] = 1'b1;
    n0 = issues;
    k = 0;
    while (issues == n0 && k < 30) begin
      tick();
      k++;
    end
    chk("write_gap_exact", 64'(cyc - t0), 64'(G + 2));

    // busy rising mid-read: read completes, no new grant
    initial_busy = 1'b1;
    set_req(2, 17'h0_0789, 1'b0, 8'h00);
    rem[2] = 1;
    req_valid[2] = 1'b1;
    n0 = issues;
    repeat (30) tick();
    chk("busy_mid_no_grant", 64'(issues), 64'(n0));
    chk("busy_mid_read_done", 64'(rq.size()), 64'd0);
    push_grant(2);
    initial_busy = 1'b0;
    drain(100);

    // table of simultaneous request patterns
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < 4; i++) begin
        set_req(i, mk_addr(v, i), vt[v].wr[i], mk_wd(v, i));
        rem[i] = vt[v].valid[i] ? 1 : 0;
      end
      for (int j = 0; j < vt[v].n; j++) push_grant(vt[v].ord[j]);
      req_valid = vt[v].valid;
      drain(400);
    end

    // CPU and command stream; sprite cuts in after four grants
    set_req(2, mk_addr(20, 2), 1'b0, 8'h00);
    set_req(3, mk_addr(20, 3), 1'b0, 8'h00);
    rem[2] = 3;
    rem[3] = 3;
    push_grant(2); push_grant(3); push_grant(2); push_grant(3);
    n0 = issues;
    req_valid[3:2] = 2'b11;
    k = 0;
    while (issues < n0 + 4 && k < 200) begin
      tick();
      k++;
    end
    chk("stream_four_grants", 64'(issues - n0), 64'd4);
    set_req(1, mk_addr(20, 1), 1'b0, 8'h00);
    push_grant(1); push_grant(2); push_grant(3);
    rem[1] = 1;
    req_valid[1] = 1'b1;
    drain(300);

    // CPU read with fixed model data
    fix_en = 1'b1;
    fix_data = 32'h0302_0100;
    set_req(2, 17'h0_0123, 1'b0, 8'h00);
    push_grant(2);
    rem[2] = 1;
    req_valid[2] = 1'b1;
    drain(100);
    chk("cpu_rdata_hold", 64'(req_rdata), 64'(32'h0302_0100));
    fix_en = 1'b0;

    // read with no SDRAM answer
    sdram_en = 1'b0;
    set_req(2, 17'h1_ABCD, 1'b0, 8'h00);
    push_grant(2);
    rem[2] = 1;
    req_valid[2] = 1'b1;
    tick();
    chk("stuck_issue", 64'(vram_valid), 64'd1);
    t0 = cyc;
    set_req(3, 17'h0_BEEF, 1'b1, 8'h77);
    rem[3] = 1;
    req_valid[3] = 1'b1;
    n0 = issues;
`ifdef VDP_VRAM_ARB_TIMEOUT_EN
    push_grant(3);
    k = 0;
    while (issues == n0 && k < TO + 20) begin
      tick();
      k++;
    end
    chk("timeout_regrant_cycle", 64'(cyc - t0), 64'(TO + 2));
    chk("timeout_flag", 64'(timeout_error), 64'd1);
    drain(50);
    set_req(2, 17'h1_ABCD, 1'b0, 8'h00);
    push_grant(2);
    rem[2] = 1;
    req_valid[2] = 1'b1;
    tick();
`else
    repeat (100) tick();
    chk("no_timeout_no_grant", 64'(issues), 64'(n0));
    chk("timeout_flag_tied", 64'(timeout_error), 64'd0);
`endif
    repeat (5) tick();

    // async reset in WAIT_RD, then a late strobe is ignored
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_a", 64'({req_ready, req_rdata_en, vram_address,
                              vram_write, vram_valid, vram_wdata}), 64'd0);
    chk("async_reset_b", 64'({req_rdata, timeout_error}), 64'd0);
    req_valid = '0;
    for (int i = 0; i < 4; i++) rem[i] = 0;
    gq.delete();
    rq.delete();
    rd_cnt = 0;
    last_iss = -1;
    repeat (2) tick();
    reset_n = 1'b1;
    sdram_en = 1'b1;
    tick();
    vram_rdata = 32'hDEAD_BEEF;
    vram_rdata_en = 1'b1;
    repeat (3) begin
      tick();
      chk("late_rdata_ignored", 64'(req_rdata_en), 64'd0);
    end
    chk("late_rdata_not_latched", 64'(req_rdata), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
